param_sync_fifo: RTL and testbench

Single-clock, parametrised synchronous FIFO. It is the next generation of the UART controller's buffer and is used for both the TX and RX queues of the UART controller.
- Generalised in data width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and an optional first-word-fall-through (FWFT) read mode.
- Storage is a circular buffer addressed by wrap-bit pointers.

---
 rtl/param_sync_fifo.sv | 81 ++++++++
 tb/tb_param_sync_fifo.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock circular-buffer FIFO with wrap-bit pointers,
// occupancy/threshold flags, sticky error flags, flush and optional FWFT read.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_POW  = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush_in,
    input  logic                  wrEn_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rdEn_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  dataValid_out,
    input  logic [DEPTH_POW:0]    afThresh_in,
    input  logic [DEPTH_POW:0]    aeThresh_in,
    input  logic                  errClr_in,
    output logic [DEPTH_POW:0]    count_out,
    output logic                  full_flag,
    output logic                  empty_flag,
    output logic                  almostFull_flag,
    output logic                  almostEmpty_flag,
    output logic                  overflow_flag,
    output logic                  underflow_flag
);
    localparam int DEPTH = 1 << DEPTH_POW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_POW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_word;
    logic                  vld_q, vld_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        count_out        = wr_ptr_q - rd_ptr_q;
        empty_flag       = wr_ptr_q == rd_ptr_q;
        full_flag        = (wr_ptr_q[DEPTH_POW] != rd_ptr_q[DEPTH_POW]) &&
                           (wr_ptr_q[DEPTH_POW-1:0] == rd_ptr_q[DEPTH_POW-1:0]);
        almostFull_flag  = count_out >= afThresh_in;
        almostEmpty_flag = count_out <= aeThresh_in;
        wr_acc           = wrEn_in && !full_flag && !flush_in;
        rd_acc           = rdEn_in && !empty_flag && !flush_in;
        wr_ptr_d         = flush_in ? '0 : wr_ptr_q + (DEPTH_POW+1)'(wr_acc);
        rd_ptr_d         = flush_in ? '0 : rd_ptr_q + (DEPTH_POW+1)'(rd_acc);
        rd_word          = mem[rd_ptr_q[DEPTH_POW-1:0]];
        dout_d           = rd_acc ? rd_word : dout_q;
        vld_d            = rd_acc;
        // a new error in the same cycle as a clear must survive
        ovf_d            = (wrEn_in && full_flag && !flush_in) || (ovf_q && !errClr_in);
        udf_d            = (rdEn_in && empty_flag && !flush_in) || (udf_q && !errClr_in);
        data_out         = (FWFT != 0) ? rd_word : dout_q;
        dataValid_out    = (FWFT != 0) ? !empty_flag : vld_q;
        overflow_flag    = ovf_q;
        underflow_flag   = udf_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // storage is not reset; a write racing reset is dropped
    always_ff @(posedge clk_in) begin
        if (wr_acc && !rst_in)
            mem[wr_ptr_q[DEPTH_POW-1:0]] <= data_in;
    end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for param_sync_fifo, registered-read
// instance driven against a count/queue model plus a small FWFT instance.
module tb_param_sync_fifo;
    logic       clk_in = 1'b0;
    logic       rst_in, flush_in, wr_en, rd_en, err_clr;
    logic [7:0] din, dout;
    logic       dv;
    logic [4:0] af_th, ae_th, cnt;
    logic       full, empty, af, ae, ovf, udf;

    logic       f_flush, f_wr, f_rd, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_cnt;

    int         n_chk = 0, n_fail = 0;
    logic [7:0] sb[$];
    int         mcnt;
    logic       m_ovf, m_udf;

    always #5 clk_in = ~clk_in;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH_POW(4), .FWFT(0)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .wrEn_in(wr_en),
        .data_in(din), .rdEn_in(rd_en), .data_out(dout), .dataValid_out(dv),
        .afThresh_in(af_th), .aeThresh_in(ae_th), .errClr_in(err_clr),
        .count_out(cnt), .full_flag(full), .empty_flag(empty),
        .almostFull_flag(af), .almostEmpty_flag(ae),
        .overflow_flag(ovf), .underflow_flag(udf)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH_POW(4), .FWFT(1)) u_fwft (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(f_flush), .wrEn_in(f_wr),
        .data_in(f_din), .rdEn_in(f_rd), .data_out(f_dout), .dataValid_out(f_dv),
        .afThresh_in(af_th), .aeThresh_in(ae_th), .errClr_in(f_clr),
        .count_out(f_cnt), .full_flag(f_full), .empty_flag(f_empty),
        .almostFull_flag(f_af), .almostEmpty_flag(f_ae),
        .overflow_flag(f_ovf), .underflow_flag(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_status();
        chk("count", 32'(cnt), 32'(mcnt));
        chk("full", 32'(full), 32'(mcnt == 16));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("almost_full", 32'(af), 32'(mcnt >= int'(af_th)));
        chk("almost_empty", 32'(ae), 32'(mcnt <= int'(ae_th)));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("underflow", 32'(udf), 32'(m_udf));
    endtask

    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr);
        logic wacc, racc;
        logic [7:0] exp_d;
        wacc = wr && mcnt != 16 && !fl;
        racc = rd && mcnt != 0 && !fl;
        wr_en = wr; din = d; rd_en = rd; flush_in = fl; err_clr = clr;
        @(posedge clk_in); #1;
        wr_en = 0; rd_en = 0; flush_in = 0; err_clr = 0;
        m_ovf = (wr && mcnt == 16 && !fl) || (m_ovf && !clr);
        m_udf = (rd && mcnt == 0 && !fl) || (m_udf && !clr);
        chk("data_valid", 32'(dv), 32'(racc));
        if (dv) begin
            if (sb.size() == 0) chk("sb_underrun", 32'(dout), 32'hFFFF_FFFF);
            else begin
                exp_d = sb.pop_front();
                chk("rd_data", 32'(dout), 32'(exp_d));
            end
        end
        if (fl) sb.delete();
        else if (wacc) sb.push_back(d);
        mcnt = fl ? 0 : mcnt + int'(wacc) - int'(racc);
        chk_status();
    endtask

    initial begin
        logic [7:0] held;
        rst_in = 1; flush_in = 0; wr_en = 0; rd_en = 0; err_clr = 0; din = 0;
        f_flush = 0; f_wr = 0; f_rd = 0; f_clr = 0; f_din = 0;
        af_th = 0; ae_th = 3;
        mcnt = 0; m_ovf = 0; m_udf = 0;
        #12;
        chk("rst_af_thresh0", 32'(af), 32'd1);
        chk("rst_data_out", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dv), 32'd0);
        af_th = 12;
        #1;
        chk_status();
        @(negedge clk_in) rst_in = 0;

        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'hAA, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);

        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 8'h77, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);

        for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 5; i < 45; i++) cyc(1, 8'(i), 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);

        for (int i = 0; i < 16; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0);
        cyc(1, 8'hBB, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
        held = dout;
        cyc(1, 8'h99, 1, 1, 0);
        chk("flush_data_hold", 32'(dout), 32'(held));

        for (int i = 0; i < 7; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
        wr_en = 1; din = 8'hEE;
        #2 rst_in = 1;
        #1;
        mcnt = 0; m_ovf = 0; m_udf = 0; sb.delete();
        chk("async_rst_valid", 32'(dv), 32'd0);
        chk("async_rst_data", 32'(dout), 32'd0);
        chk_status();
        wr_en = 0;
        @(negedge clk_in) rst_in = 0;
        cyc(0, 0, 0, 0, 0);

        f_wr = 1; f_din = 8'h5A;
        @(posedge clk_in); #1; f_wr = 0;
        chk("fwft_data", 32'(f_dout), 32'h5A);
        chk("fwft_valid", 32'(f_dv), 32'd1);
        f_wr = 1; f_din = 8'h3C;
        @(posedge clk_in); #1; f_wr = 0;
        chk("fwft_hold", 32'(f_dout), 32'h5A);
        chk("fwft_count", 32'(f_cnt), 32'd2);
        f_rd = 1;
        @(posedge clk_in); #1; f_rd = 0;
        chk("fwft_pop1", 32'(f_dout), 32'h3C);
        chk("fwft_valid1", 32'(f_dv), 32'd1);
        f_rd = 1;
        @(posedge clk_in); #1; f_rd = 0;
        chk("fwft_valid_empty", 32'(f_dv), 32'd0);
        chk("fwft_empty", 32'(f_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
